// File: rtl/tt_um_hoene_led_bit_decoder.sv
// Smart-LED bit decoder.
// Takes the de-glitched data line and measures each high pulse to classify it as
// a 0 or 1 bit. Bits are packed MSB-first into 24-bit pixel words, which are
// offered downstream over a valid/ready handshake. A long low gap ends the frame,
// and a high level lasting that long is treated as a line fault.
module tt_um_hoene_led_bit_decoder #(
  parameter int unsigned CNT_WIDTH     = 12,
  parameter int unsigned BIT_THRESHOLD = 30,
  parameter int unsigned RESET_CYCLES  = 2500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in,
  output logic [23:0] data,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        frame_end,
  output logic        in_sync,
  output logic        overrun
);

  // Line-tracking states.
  localparam logic [1:0] ST_SYNC = 2'd0;  // waiting for a reset-length low gap
  localparam logic [1:0] ST_GAP  = 2'd1;  // synchronised, idle low between frames
  localparam logic [1:0] ST_HIGH = 2'd2;  // measuring a high pulse
  localparam logic [1:0] ST_LOW  = 2'd3;  // measuring the low after a bit

  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] GAP_LEN    = CNT_WIDTH'(RESET_CYCLES);
  localparam logic [CNT_WIDTH-1:0] ONE_LEN    = CNT_WIDTH'(BIT_THRESHOLD);
  localparam logic [4:0]           LAST_BIT   = 5'd23;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [22:0]          shift_q, shift_d;
  logic [23:0]          data_q, data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 frame_end_q, frame_end_d;
  logic                 overrun_q, overrun_d;

  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 cnt_at_gap;
  logic                 bit_strobe;
  logic                 bit_value;
  logic                 word_done;

  // Saturating increment of the pulse/gap counter; the limit check uses the
  // post-increment value so a run of L samples is recognised on its L-th sample.
  always_comb begin
    cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    cnt_at_gap = (cnt_inc >= GAP_LEN);
  end

  // Line state machine: pulse measurement, bit classification, gap/fault detection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_end_d = 1'b0;
    bit_strobe  = 1'b0;
    bit_value   = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (in) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_at_gap) begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (in) begin
          cnt_d   = CNT_ONE;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (in) begin
          cnt_d = cnt_inc;
          if (cnt_at_gap) begin
            // Stuck-high line: drop back to hunting for a clean gap.
            cnt_d   = '0;
            state_d = ST_SYNC;
          end
        end else begin
          // cnt_q holds the full high length here, so classify on it directly.
          bit_strobe = 1'b1;
          bit_value  = (cnt_q >= ONE_LEN);
          cnt_d      = CNT_ONE;
          state_d    = ST_LOW;
        end
      end
      default: begin  // ST_LOW
        if (!in) begin
          cnt_d = cnt_inc;
          if (cnt_at_gap) begin
            frame_end_d = 1'b1;
            state_d     = ST_GAP;
          end
        end else begin
          cnt_d   = CNT_ONE;
          state_d = ST_HIGH;
        end
      end
    endcase
  end

  // Bit assembly into the shift register; a fault or frame gap discards the partial word.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    word_done = bit_strobe && (bit_cnt_q == LAST_BIT);
    if ((state_q == ST_HIGH) && in && cnt_at_gap) begin
      bit_cnt_d = '0;
    end else if (frame_end_d) begin
      bit_cnt_d = '0;
    end else if (bit_strobe) begin
      if (word_done) begin
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 5'd1;
        shift_d   = {shift_q[21:0], bit_value};
      end
    end
  end

  // Output word handshake: load when the slot is free or being drained this cycle,
  // otherwise keep the held word and flag the loss.
  always_comb begin
    data_d       = data_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
    if (word_done) begin
      if (!data_valid_q || data_ready) begin
        data_d       = {shift_q, bit_value};
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SYNC;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_end_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_end_q  <= frame_end_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign frame_end  = frame_end_q;
  assign overrun    = overrun_q;
  assign in_sync    = (state_q != ST_SYNC);

endmodule

// File: tb/tb_tt_um_hoene_led_bit_decoder.sv
// Bench for the smart-LED bit decoder: directed pulse trains plus a run-length
// reference model compared against the outputs every cycle.
module tb_tt_um_hoene_led_bit_decoder;

  localparam int GAP_LEN = 2500;
  localparam int ONE_LEN = 30;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_sig;
  logic [23:0] data;
  logic        data_valid;
  logic        data_ready;
  logic        frame_end;
  logic        in_sync;
  logic        overrun;

  int passed = 0;
  int total  = 0;
  int fe_count = 0;
  bit cmp_en = 1'b0;

  // Reference model state, described in terms of line run lengths.
  int          run;
  int          lvl;
  bit          synced;
  bit          low_after_bit;
  logic [23:0] sh;
  int          nbits;
  logic [23:0] exp_data;
  logic        exp_valid;
  logic        exp_fe;
  logic        exp_ovr;

  tt_um_hoene_led_bit_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in_sig),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_end  (frame_end),
    .in_sync    (in_sync),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: advance one sample at every rising edge.
  initial begin
    forever begin
      int  prev_run;
      int  prev_lvl;
      bit  hs;
      bit  b;
      bit  completed;
      @(posedge clk);
      if (rst) begin
        run = 0; lvl = -1; synced = 0; low_after_bit = 0; sh = '0; nbits = 0;
        exp_data = '0; exp_valid = 0; exp_fe = 0; exp_ovr = 0;
      end else begin
        prev_run = run;
        prev_lvl = lvl;
        hs = exp_valid && data_ready;
        completed = 0;
        exp_fe = 0;
        if (int'(in_sig) == lvl) run++;
        else begin lvl = int'(in_sig); run = 1; end
        if (!synced) begin
          if (in_sig == 1'b0 && run == GAP_LEN) begin
            synced = 1; low_after_bit = 0;
          end
        end else if (in_sig == 1'b1 && run == GAP_LEN) begin
          synced = 0; nbits = 0; low_after_bit = 0;
        end else if (in_sig == 1'b0 && prev_lvl == 1) begin
          b = (prev_run >= ONE_LEN);
          sh = {sh[22:0], b};
          nbits++;
          low_after_bit = 1;
          if (nbits == 24) begin
            nbits = 0;
            completed = 1;
            if (!exp_valid || data_ready) begin exp_data = sh; exp_valid = 1; end
            else exp_ovr = 1;
          end
        end else if (in_sig == 1'b0 && low_after_bit && run == GAP_LEN) begin
          exp_fe = 1; nbits = 0; low_after_bit = 0;
        end
        if (!completed && hs) exp_valid = 0;
      end
    end
  end

  // Compare process: outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("data", 32'(data), 32'(exp_data));
        check("data_valid", 32'(data_valid), 32'(exp_valid));
        check("frame_end", 32'(frame_end), 32'(exp_fe));
        check("in_sync", 32'(in_sync), 32'(synced));
        check("overrun", 32'(overrun), 32'(exp_ovr));
      end
    end
  end

  // Transaction log.
  initial begin
    forever begin
      @(negedge clk);
      if (frame_end) begin
        fe_count++;
        $display("[%0t] frame_end pulse", $time);
      end
      if (data_valid && data_ready)
        $display("[%0t] word accepted data=%06h overrun=%0b", $time, data, overrun);
    end
  end

  // Hold the line at v for n sampled edges; called and returning at a falling edge.
  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      in_sig = v;
      @(negedge clk);
    end
  endtask

  task automatic send_bit(input int h, input int l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--) begin
      if (w[i]) send_bit(40, 40);
      else      send_bit(20, 60);
    end
  endtask

  // Full word; checks the output right after the 24th falling sample and one cycle later.
  task automatic send_word(input logic [23:0] w, input logic rdy_end,
                           input logic [23:0] exp_d, input string tag);
    int h;
    int l;
    send_bits(w, 23);
    h = w[0] ? 40 : 20;
    l = w[0] ? 40 : 60;
    drive(1'b1, h);
    data_ready = rdy_end;
    drive(1'b0, 1);
    check({tag, "_data"}, 32'(data), 32'(exp_d));
    check({tag, "_valid"}, 32'(data_valid), 32'd1);
    drive(1'b0, 1);
    check({tag, "_valid_next"}, 32'(data_valid), 32'(!rdy_end));
    drive(1'b0, l - 2);
    $display("[%0t] sent word %06h", $time, w);
  endtask

  initial begin
    rst = 1'b1;
    in_sig = 1'b0;
    data_ready = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;
    check("reset_valid", 32'(data_valid), 32'd0);
    check("reset_in_sync", 32'(in_sync), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Sync-up
    drive(1'b0, GAP_LEN - 1);
    check("sync_before", 32'(in_sync), 32'd0);
    drive(1'b0, 1);
    check("sync_after", 32'(in_sync), 32'd1);
    check("sync_no_fe", 32'(fe_count), 32'd0);
    drive(1'b0, 10);

    // One word
    send_word(24'hA53C0F, 1'b1, 24'hA53C0F, "word1");

    // Threshold edges: 29 -> 0, 30 -> 1, alternating from the MSB
    for (int i = 23; i >= 0; i--) send_bit((i % 2 == 1) ? 30 : 29, 50);
    check("threshold_word", 32'(data), 32'hAAAAAA);
    $display("[%0t] sent threshold word", $time);

    // Back-pressure
    data_ready = 1'b0;
    send_word(24'h123456, 1'b0, 24'h123456, "bp1");
    send_word(24'hABCDEF, 1'b0, 24'h123456, "bp2");
    check("bp_overrun", 32'(overrun), 32'd1);
    data_ready = 1'b0;
    send_word(24'h0F0F0F, 1'b1, 24'h0F0F0F, "bp3");
    check("bp3_overrun", 32'(overrun), 32'd1);

    // Partial frame
    send_bits(24'hFFC000, 10);
    drive(1'b0, GAP_LEN);
    check("partial_fe", 32'(fe_count), 32'd1);
    check("partial_no_valid", 32'(data_valid), 32'd0);
    send_word(24'h5A5A5A, 1'b1, 24'h5A5A5A, "after_partial");

    // Stuck-high fault, then resync without a frame_end
    drive(1'b1, GAP_LEN - 1);
    check("fault_before", 32'(in_sync), 32'd1);
    drive(1'b1, 1);
    check("fault_in_sync", 32'(in_sync), 32'd0);
    drive(1'b0, GAP_LEN + 5);
    check("resync_in_sync", 32'(in_sync), 32'd1);
    check("resync_no_fe", 32'(fe_count), 32'd1);

    // Reset mid-word with a pending word
    data_ready = 1'b0;
    send_word(24'h3C3C3C, 1'b0, 24'h3C3C3C, "pre_rst");
    send_bits(24'hF00000, 5);
    drive(1'b1, 10);
    rst = 1'b1;
    drive(1'b1, 1);
    check("rst_data", 32'(data), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_fe", 32'(frame_end), 32'd0);
    check("rst_in_sync", 32'(in_sync), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    drive(1'b0, 20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tt_um_hoene_led_bit_decoder.md
# tt_um_hoene_led_bit_decoder

Decodes the de-glitched smart-LED data line into 24-bit pixel words. It sits directly downstream of the 5-sample low-pass filter and consumes its `out` signal. It measures each high-pulse width to classify bits, assembles bits MSB-first into 24-bit words, and hands each word to the pixel stage over a valid/ready handshake. A long low period (latch/reset gap) marks the frame boundary.

## Interface
- `CNT_WIDTH`, 12: width of the pulse/gap counter; counter saturates at 2^CNT_WIDTH−1.
- `BIT_THRESHOLD`, 30: high-pulse length in cycles at or above which a bit decodes as 1.
- `RESET_CYCLES`, 2500: low-gap length in cycles that ends a frame; also the high length treated as a line fault. Must be < 2^CNT_WIDTH.
- `clk`  in  1  global clock.
- `rst`  in  1  synchronous, active-high reset.
- `in`  in  1  filtered data line (low-pass filter output).
- `data`  out  24  assembled word; first received bit in `data[23]`.
- `data_valid`  out  1  `data` holds an unconsumed word.
- `data_ready`  in  1  consumer accepts `data` when `data_valid && data_ready` at a clock edge.
- `frame_end`  out  1  one-cycle pulse when a low gap reaches `RESET_CYCLES`.
- `in_sync`  out  1  high when the decoder is synchronised, i.e. in any state except SYNC.
- `overrun`  out  1  sticky; set when a completed word is dropped. Cleared only by `rst`.

## Operation
- Internal state: `state`, `cnt[CNT_WIDTH-1:0]`, `bit_cnt[4:0]`, `shift[22:0]`.
- All of these update on `posedge clk` from the value of `in` sampled at that edge.
- States and transitions:
  - **SYNC**: entered on reset and on fault. Counts consecutive low samples. A high sample clears `cnt`. When `cnt` reaches `RESET_CYCLES`, go to GAP. No `frame_end` is issued on leaving SYNC.
  - **GAP**: idle low. On a high sample: set `cnt`=1 and go to HIGH.
  - **HIGH**: on a high sample, `cnt`+1.
    - If `cnt` reaches `RESET_CYCLES`, this is a fault: go to SYNC and discard partial bits.
    - On a low sample: bit = (`cnt` ≥ `BIT_THRESHOLD`). Shift the bit in, `bit_cnt`+1, set `cnt`=1, go to LOW.
  - **LOW**: on a low sample, `cnt`+1.
    - If `cnt` reaches `RESET_CYCLES`: pulse `frame_end`, clear `bit_cnt` (the partial word is discarded), go to GAP.
    - On a high sample: set `cnt`=1 and go to HIGH.
- Word completion happens on the 24th bit, i.e. `bit_cnt`==23 when the bit is shifted in. Then:
  - Word = {`shift`, bit}. Set `bit_cnt`=0.
  - If `data_valid` is 0, or `data_ready` is 1 in the same cycle: load `data`, and `data_valid`=1.
  - Otherwise: keep the old `data`, drop the new word, set `overrun`=1.
- Handshake: when `data_valid && data_ready` and no word completes that cycle, clear `data_valid`. `data` is held stable while `data_valid`=1 and un-accepted.
- Counters saturate and never wrap.
- Pulse lengths count sampled cycles. A high of L samples yields `cnt`=L at classification.

## Timing
- Reset values:
  - `data`=0, `data_valid`=0, `frame_end`=0, `overrun`=0, `in_sync`=0.
  - `state`=SYNC, `cnt`=0, `bit_cnt`=0.
- Bit latency: a bit is classified at the edge that samples the first low after its high.
- `data_valid` latency: `data`/`data_valid` update at that same edge for the 24th bit, visible 1 cycle after the falling sample.
- `frame_end` latency: `frame_end` is high for exactly the one cycle following the edge where the low count reaches `RESET_CYCLES`.
- Simultaneous completion and accept: no gap; `data_valid` stays 1 with the new word.
- `rst` mid-word or mid-handshake: everything returns to reset values next edge; the pending word is lost.
- A fault in HIGH does not pulse `frame_end` and does not touch `data`/`data_valid`.

## Test plan
- **Sync-up**: `rst` 2 cycles, then `in`=0 for 2500 cycles. Require `in_sync`=1 after the 2500th sample, and no `frame_end` pulse.
- **One word**: bit 1 = high 40 / low 40; bit 0 = high 20 / low 60. Send 0xA53C0F with `data_ready`=1. Require `data`=0xA53C0F and `data_valid` for exactly 1 cycle after the 24th falling sample.
- **Threshold edges**: highs of 29 and 30 cycles. Require bits 0 and 1 respectively.
- **Back-pressure**: `data_ready`=0, send 0x123456 then 0xABCDEF. Require `data` stays 0x123456 and `overrun`=1. Then complete the 3rd word while `data_ready`=1 in the same cycle: require `data` = the new word, `data_valid` stays 1, and `overrun` is still 1.
- **Partial frame**: send 10 bits, then low 2500. Require a `frame_end` pulse, no `data_valid`, and a following full word decoding correctly.
- **Fault / reset**:
  - `in` high 2500 cycles: require `in_sync`=0.
  - `rst` asserted mid-word: require all outputs at reset values next cycle.
